fft_bin_reader: RTL and testbench

- Read-side controller for the FFT sample RAM (single-port, 512 x 32 words).
- Once the FFT has finished, it walks the bins in order: it issues read addresses, absorbs the RAM's 1-cycle synchronous read latency and computes squared magnitude (re^2 + im^2) per bin.
- Results go out on a valid/ready stream to downstream peak detection / pitch logic.
- Only RAM reads are issued; the block never writes.

---
 rtl/fft_bin_reader.sv | 128 ++++++++++++
 tb/tb_fft_bin_reader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bin_reader.sv
// fft_bin_reader
//   Read-side controller for the FFT sample RAM. When started, it walks bins
//   0..NUM_BINS-1 in order. For each bin it issues the read address, waits
//   out the RAM's one-cycle synchronous read latency, latches the complex
//   sample and computes the squared magnitude re^2 + im^2. Each result is
//   presented on a valid/ready stream. The block only reads the RAM.
//
// Ports
//   clk           system clock
//   reset         asynchronous active-low reset
//   start         begin a sweep (sampled only while idle)
//   ram_address   RAM address, always equal to the bin counter
//   ram_we        RAM write enable, tied low
//   ram_data_in   RAM write data, tied to zero
//   ram_data_out  RAM read data: [31:16] real, [15:0] imag, signed
//   mag           unsigned squared magnitude of the presented bin
//   bin_idx       bin index that belongs to mag
//   out_valid     mag/bin_idx valid
//   out_ready     downstream accepts the presented result
//   busy          high whenever a sweep is in progress
//   done          one-cycle pulse after the last bin has been accepted

module fft_bin_reader #(
   parameter int ADDR_W   = 9,
   parameter int NUM_BINS = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_we,
   output logic [31:0]       ram_data_in,
   input  logic [31:0]       ram_data_out,
   output logic [31:0]       mag,
   output logic [ADDR_W-1:0] bin_idx,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NUM_BINS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_LATCH,
      S_CALC,
      S_OUT,
      S_DONE
   } state_t;

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   cnt;
   logic signed [15:0]  re_q, im_q;
   logic signed [31:0]  re_sq, im_sq;
   logic [31:0]         mag_sum;
   logic                last_bin;

   // Each square is at most 2^30, so the sum tops out at 2^31 and always
   // fits the unsigned 32-bit result.
   assign re_sq    = re_q * re_q;
   assign im_sq    = im_q * im_q;
   assign mag_sum  = $unsigned(re_sq) + $unsigned(im_sq);
   assign last_bin = (cnt == LAST_BIN);

   assign ram_address = cnt;
   assign ram_we      = 1'b0;
   assign ram_data_in = '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      out_valid = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nx = S_ISSUE;
         end
         // RAM captures ram_address at the edge that ends this state.
         S_ISSUE: state_nx = S_LATCH;
         S_LATCH: state_nx = S_CALC;
         S_CALC:  state_nx = S_OUT;
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = last_bin ? S_DONE : S_ISSUE;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         re_q    <= '0;
         im_q    <= '0;
         mag     <= '0;
         bin_idx <= '0;
      end else begin
         case (state)
            S_IDLE:  if (start) cnt <= '0;
            S_LATCH: begin
               re_q <= ram_data_out[31:16];
               im_q <= ram_data_out[15:0];
            end
            S_CALC: begin
               mag     <= mag_sum;
               bin_idx <= cnt;
            end
            // cnt stops at the last bin; it is cleared on the way out.
            S_OUT:   if (out_ready && !last_bin) cnt <= cnt + 1'b1;
            S_DONE:  cnt <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_bin_reader.sv
module tb_fft_bin_reader;

   localparam int AW = 9;
   localparam int NB = 256;

   logic          clk = 1'b0;
   logic          reset, start, start1;
   logic          out_ready  = 1'b1;
   logic          out_ready1 = 1'b1;
   logic [AW-1:0] ram_address, ram_address1, bin_idx, bin_idx1;
   logic          ram_we, ram_we1, out_valid, out_valid1, busy, busy1, done, done1;
   logic [31:0]   ram_data_in, ram_data_in1, ram_data_out, ram_data_out1, mag, mag1;
   logic [31:0]   mem [0:511];

   always #5 clk = ~clk;

   fft_bin_reader #(.ADDR_W(AW), .NUM_BINS(NB)) dut (
      .clk(clk), .reset(reset), .start(start),
      .ram_address(ram_address), .ram_we(ram_we), .ram_data_in(ram_data_in),
      .ram_data_out(ram_data_out), .mag(mag), .bin_idx(bin_idx),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done));

   fft_bin_reader #(.ADDR_W(AW), .NUM_BINS(1)) u_one (
      .clk(clk), .reset(reset), .start(start1),
      .ram_address(ram_address1), .ram_we(ram_we1), .ram_data_in(ram_data_in1),
      .ram_data_out(ram_data_out1), .mag(mag1), .bin_idx(bin_idx1),
      .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1), .done(done1));

   // single-port RAM, one-cycle synchronous read
   always @(posedge clk) ram_data_out  <= mem[ram_address];
   always @(posedge clk) ram_data_out1 <= mem[ram_address1];

   int errors = 0, checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting", name);
   endtask

   // reference: squared magnitude from the signed halves, plain integer math
   function automatic logic [31:0] mag_of(input logic [31:0] w);
      longint re, im;
      re = longint'($signed(w[31:16]));
      im = longint'($signed(w[15:0]));
      return 32'(re * re + im * im);
   endfunction

   typedef struct {
      logic [AW-1:0] bin;
      logic [31:0]   mag;
   } exp_t;
   exp_t q[$];

   int            cyc = 0;
   int            start_cyc = 0;
   bit            first_pend = 0, timing_chk = 0, held_v = 0, we_seen = 0;
   int            done_cnt = 0;
   logic [31:0]   held_mag;
   logic [AW-1:0] held_bin, held_addr;

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: samples on the falling edge; out_ready is stable until the
   // next rising edge, so valid&&ready here is exactly the coming handshake
   always @(negedge clk) begin
      if (ram_we !== 1'b0 || ram_data_in !== 32'h0) we_seen = 1;
      if (reset === 1'b1) begin
         if (out_valid) begin
            if (first_pend) begin
               chk("first_latency", 64'(cyc - start_cyc), 64'd3);
               first_pend = 0;
            end
            chk("addr_eq_bin", 64'(ram_address), 64'(bin_idx));
            if (held_v) begin
               chk("stall_mag",  64'(mag), 64'(held_mag));
               chk("stall_bin",  64'(bin_idx), 64'(held_bin));
               chk("stall_addr", 64'(ram_address), 64'(held_addr));
            end
            if (out_ready) begin
               held_v = 0;
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out: bin %0d with empty scoreboard", bin_idx);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  chk("bin_idx", 64'(bin_idx), 64'(e.bin));
                  chk("mag", 64'(mag), 64'(e.mag));
               end
            end else begin
               held_v    = 1;
               held_mag  = mag;
               held_bin  = bin_idx;
               held_addr = ram_address;
            end
         end else begin
            held_v = 0;
         end
         if (done) begin
            done_cnt++;
            chk("done_q_empty", 64'(q.size()), 64'd0);
            if (timing_chk) chk("done_time", 64'(cyc - start_cyc), 64'(4 * NB));
         end
      end
   end

   // out_ready driver: mode 0 always ready; mode 1 random with a 10-cycle
   // stall the first time bin 5 is presented
   int rdy_mode = 0, stall_left = 0;
   bit stalled5 = 0;
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else begin
         if (out_valid && bin_idx == 5 && !stalled5) begin
            stalled5   = 1;
            stall_left = 10;
         end
         if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic run_sweep();
      for (int i = 0; i < NB; i++) begin
         exp_t e;
         e.bin = AW'(i);
         e.mag = mag_of(mem[i]);
         q.push_back(e);
      end
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      start_cyc  = cyc;
      first_pend = 1;
   endtask

   task automatic wait_done(input int budget, input bit start_on_done, input string name);
      int  n;
      bit  seen;
      n    = done_cnt;
      seen = 0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(posedge clk); #1;
         if (done) seen = 1;
      end
      if (!seen) tmo(name);
      else if (start_on_done) begin
         start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      repeat (6) @(posedge clk);
      #1;
      chk({name, "_one_done"}, 64'(done_cnt), 64'(n + 1));
      chk({name, "_idle"}, 64'(busy), 64'd0);
      chk({name, "_q_empty"}, 64'(q.size()), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int s;
      reset = 1'b0; start = 1'b0; start1 = 1'b0;
      for (int i = 0; i < 512; i++) begin
         logic [15:0] re, im;
         re = 16'(i);
         im = 16'(-i);
         mem[i] = {re, im};
      end
      mem[0] = 32'h0003_FFFC;
      mem[1] = 32'h8000_8000;
      mem[2] = 32'h7FFF_0000;
      mem[3] = 32'h0000_0000;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_mag", 64'(mag), 64'd0);
      chk("rst_bin", 64'(bin_idx), 64'd0);
      chk("rst_addr", 64'(ram_address), 64'd0);
      chk("rst_we", 64'(ram_we), 64'd0);
      chk("rst_one_valid", 64'(out_valid1), 64'd0);
      @(negedge clk) reset = 1'b1;

      // NUM_BINS=1: single bin then done
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      s = cyc;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (out_valid1) begin
            seen = 1;
            chk("one_latency", 64'(cyc - s), 64'd3);
            chk("one_mag", 64'(mag1), 64'(mag_of(mem[0])));
            chk("one_bin", 64'(bin_idx1), 64'd0);
         end
      end
      if (!seen) tmo("one_valid");
      @(negedge clk);
      chk("one_done", 64'(done1), 64'd1);
      chk("one_done_time", 64'(cyc - s), 64'd4);
      @(negedge clk);
      chk("one_idle", 64'(busy1), 64'd0);
      chk("one_no_valid", 64'(out_valid1), 64'd0);

      // sweep 1: directed corner values, always ready, exact timing
      timing_chk = 1;
      run_sweep();
      wait_done(2000, 0, "sweep1");
      timing_chk = 0;

      // sweep 2: random data, random backpressure plus a long stall on bin 5
      for (int i = 0; i < NB; i++) mem[i] = $urandom;
      mem[7] = 32'h8000_8000;
      rdy_mode = 1;
      run_sweep();
      wait_done(20000, 0, "sweep2");
      rdy_mode = 0;
      chk("stall_exercised", 64'(stalled5), 64'd1);

      // sweep 3: start re-pulsed at bin 40 and again during done
      run_sweep();
      seen = 0;
      for (int c = 0; c < 2000 && !seen; c++) begin
         @(posedge clk); #1;
         if (out_valid && bin_idx == 40) seen = 1;
      end
      if (!seen) tmo("bin40");
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(2000, 1, "sweep3");

      // sweep 4: reset while bin 100 is presented
      run_sweep();
      seen = 0;
      for (int c = 0; c < 2000 && !seen; c++) begin
         @(negedge clk);
         if (out_valid && bin_idx == 100) seen = 1;
      end
      if (!seen) tmo("bin100");
      #1 reset = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_mag", 64'(mag), 64'd0);
      chk("mid_rst_addr", 64'(ram_address), 64'd0);
      chk("mid_rst_bin", 64'(bin_idx), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      q.delete();
      held_v     = 0;
      first_pend = 0;
      s = done_cnt;
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("mid_rst_no_done", 64'(done_cnt), 64'(s));

      // sweep 5: restart from bin 0 after the abort
      timing_chk = 1;
      run_sweep();
      wait_done(2000, 0, "sweep5");
      timing_chk = 0;

      chk("ram_we_never", 64'(we_seen), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
